// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/reply bytes and
// the microsecond-to-cycle conversion used to size the transmitter timers.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_WAIT_CLK,
        ST_SHIFT,
        ST_WAIT_IDLE,
        ST_ERR
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Fall number at which the device's ACK is sampled.
    localparam logic [3:0] PS2_FALL_ACK = 4'd11;

    function automatic longint unsigned us_to_cycles(input int unsigned us,
                                                     input int unsigned hz);
        return (64'(us) * 64'(hz)) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a one-cycle
// pulse on each falling edge of the synchronized clock.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_pad_i,
    input  logic dat_pad_i,
    output logic clk_o,
    output logic dat_o,
    output logic clk_fall_o
);

    logic [1:0] clk_ff_q;
    logic [1:0] dat_ff_q;
    logic       clk_prev_q;

    // Reset to the idle-high line level so leaving reset never fakes a fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_ff_q   <= 2'b11;
            dat_ff_q   <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], clk_pad_i};
            dat_ff_q   <= {dat_ff_q[0], dat_pad_i};
            clk_prev_q <= clk_ff_q[1];
        end
    end

    assign clk_o      = clk_ff_q[1];
    assign dat_o      = dat_ff_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pads via output enables.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to RETRY_MAX extra times.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned START_TO_US = 15000,
    parameter int unsigned XFER_TO_US  = 2000,
    parameter int unsigned RETRY_MAX   = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam longint unsigned INH_CYC   = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam longint unsigned START_CYC = us_to_cycles(START_TO_US, CLK_FREQ_HZ);
    localparam longint unsigned XFER_CYC  = us_to_cycles(XFER_TO_US, CLK_FREQ_HZ);
    localparam longint unsigned MAX_CYC   =
        (INH_CYC > START_CYC) ? ((INH_CYC > XFER_CYC) ? INH_CYC : XFER_CYC)
                              : ((START_CYC > XFER_CYC) ? START_CYC : XFER_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 64'd1);
    localparam logic [TMR_W-1:0] INH_LOAD   = TMR_W'(INH_CYC - 64'd1);
    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYC - 64'd1);
    localparam logic [TMR_W-1:0] XFER_LOAD  = TMR_W'(XFER_CYC - 64'd1);
    localparam int ATT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    ps2_tx_state_e    state_q, state_d;
    logic [8:0]       frame_q, frame_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_s, dat_s, clk_fall;
    logic             fail;
    logic             retry_ok;

    ps2_sync_edge u_sync (
        .clk_i      (CLK),
        .rst_i      (rst),
        .clk_pad_i  (ps2_clk_in),
        .dat_pad_i  (ps2_dat_in),
        .clk_o      (clk_s),
        .dat_o      (dat_s),
        .clk_fall_o (clk_fall)
    );

    assign retry_ok = RETRY_ON && (32'(att_q) < RETRY_MAX);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            att_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            att_q    <= att_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        att_d    = att_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    frame_d  = {~^tx_data, tx_data};
                    state_d  = ST_INHIBIT;
                    clk_oe_d = 1'b1;
                    timer_d  = INH_LOAD;
                    cnt_d    = '0;
                    att_d    = '0;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == '0) begin
                    state_d  = ST_START;
                    dat_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_START: begin
                clk_oe_d = 1'b0;
                state_d  = ST_WAIT_CLK;
                timer_d  = START_LOAD;
            end
            ST_WAIT_CLK: begin
                if (clk_fall) begin
                    cnt_d    = 4'd1;
                    dat_oe_d = ~frame_q[0];
                    timer_d  = XFER_LOAD;
                    state_d  = ST_SHIFT;
                end else if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    if (clk_fall) begin
                        // cnt_q holds the falls already seen, so it also indexes the next bit.
                        cnt_d = (cnt_q >= PS2_FALL_ACK) ? PS2_FALL_ACK : cnt_q + 4'd1;
                        if (cnt_q <= 4'd8) begin
                            dat_oe_d = ~frame_q[cnt_q];
                        end else if (cnt_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                        end else if (!dat_s) begin
                            state_d = ST_WAIT_IDLE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_ERR: begin
                if (retry_ok) begin
                    att_d    = att_q + ATT_W'(1);
                    state_d  = ST_INHIBIT;
                    clk_oe_d = 1'b1;
                    timer_d  = INH_LOAD;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Lines are released on entry to ERR, so tx_err coincides with both oe low.
        if (fail) begin
            state_d  = ST_ERR;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_d    = ~retry_ok;
        end
    end

    assign tx_ready   = (state_q == ST_IDLE);
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device (80-cycle clock, samples on rise)
// on a wired-AND bus, with frames checked against a byte-level reference model.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned FREQ  = 1_000_000;
    localparam int unsigned INH_US = 120;
    localparam int unsigned STO_US = 3000;
    localparam int unsigned XTO_US = 2000;
    localparam int unsigned RMAX  = 2;
    localparam int INH   = 120;
    localparam int START = 3000;
    localparam int HALF  = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = RMAX + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       CLK;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low, dev_dat_low;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int inh_cnt = 0;
    logic oe_prev = 1'b0;

    ps2_host_tx #(
        .CLK_FREQ_HZ (FREQ),
        .INHIBIT_US  (INH_US),
        .START_TO_US (STO_US),
        .XFER_TO_US  (XTO_US),
        .RETRY_MAX   (RMAX)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Open-drain bus with pull-ups: low if either side pulls.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe && !oe_prev) inh_cnt <= inh_cnt + 1;
        oe_prev <= ps2_clk_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Deviation from the target, or 0 when within one cycle.
    function automatic int tol1(input int got, input int exp);
        int d;
        d = got - exp;
        return (d >= -1 && d <= 1) ? 0 : d;
    endfunction

    // Reference frame as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic dev_xfer(input bit ack, input int rst_fall,
                            output logic [9:0] bits, output int inh_len, output bit ok);
        int t;
        bits = '0;
        inh_len = 0;
        ok = 1'b0;
        t = 0;
        while (!ps2_clk_oe && t < 5000) begin @(negedge CLK); t++; end
        if (t >= 5000) return;
        while (ps2_clk_oe && inh_len < 50000) begin @(negedge CLK); inh_len++; end
        check("start_bit", ps2_dat_oe, 1);
        repeat (10) @(negedge CLK);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == rst_fall) begin
                repeat (10) @(negedge CLK);
                rst = 1'b1;
                @(negedge CLK);
                check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
                check("rst_done_err", {tx_done, tx_err}, 0);
                rst = 1'b0;
                dev_clk_low = 1'b0;
                ok = 1'b1;
                return;
            end
            repeat (HALF) @(negedge CLK);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_dat_in;
            if (k == 10 && ack) begin
                repeat (HALF / 2) @(negedge CLK);
                dev_dat_low = 1'b1;
                repeat (HALF / 2) @(negedge CLK);
            end else begin
                repeat (HALF) @(negedge CLK);
            end
        end
        dev_dat_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit chk_inh);
        logic [9:0] bits;
        int inh, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        dev_xfer(1'b1, 0, bits, inh, ok);
        check("xfer_ok", 32'(ok), 1);
        check("frame", 32'(bits), 32'(exp_frame(d)));
        if (chk_inh) check("inhibit_dev", tol1(inh, INH), 0);
        repeat (20) @(negedge CLK);
        check("done_once", done_cnt - d0, 1);
        check("no_err", err_cnt - e0, 0);
        check("oe_idle", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("ready_after", tx_ready, 1);
    endtask

    initial begin
        logic [9:0] bits;
        int inh, n, d0, e0, i0;
        bit ok;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_flags", {tx_done, tx_err}, 0);
        check("rst_oe0", {ps2_clk_oe, ps2_dat_oe}, 0);
        rst = 1'b0;
        repeat (5) @(negedge CLK);

        run_xfer(PS2_CMD_SET_LED, 1'b1);
        run_xfer(8'h01, 1'b1);
        run_xfer(8'h00, 1'b1);
        for (int r = 0; r < 4; r++) run_xfer(8'($urandom_range(0, 255)), 1'b1);

        // Device never clocks.
        e0 = err_cnt;
        send(PS2_CMD_ENABLE);
        check("busy_inhibit", tx_busy, 1);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin @(negedge CLK); n++; end
        n = 0;
        while (!tx_err && n < START + 50) begin @(negedge CLK); n++; end
        check("start_timeout_dev", tol1(n, START), 0);
        check("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        @(negedge CLK);
        check("timeout_ready", tx_ready, 1);
        repeat (10) @(negedge CLK);
        check("timeout_err_once", err_cnt - e0, 1);

        // Device omits the ACK.
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(8'h55);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_xfer(1'b0, 0, bits, inh, ok);
            check("noack_frame", 32'(bits), 32'(exp_frame(8'h55)));
        end
        repeat (30) @(negedge CLK);
        check("noack_err", err_cnt - e0, 1);
        check("noack_done", done_cnt - d0, 0);
        check("noack_inhibits", inh_cnt - i0, ATTEMPTS);
        check("noack_ready", tx_ready, 1);

        // Reset at fall #5, then a clean transfer.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h0F);
        dev_xfer(1'b1, 5, bits, inh, ok);
        repeat (20) @(negedge CLK);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);
        check("rst_ready_after", tx_ready, 1);
        run_xfer(PS2_CMD_ENABLE, 1'b1);

        // Request while busy is dropped.
        d0 = done_cnt; i0 = inh_cnt;
        send(PS2_CMD_RESET);
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        repeat (50) @(negedge CLK);
        check("busy_ready", tx_ready, 0);
        tx_valid = 1'b0;
        dev_xfer(1'b1, 0, bits, inh, ok);
        check("busy_frame", 32'(bits), 32'(exp_frame(PS2_CMD_RESET)));
        repeat (200) @(negedge CLK);
        check("busy_done", done_cnt - d0, 1);
        check("busy_one_xfer", inh_cnt - i0, 1);
        check("busy_idle", tx_busy, 0);

        check("done_err_excl", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
